// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants, state type and channel helper for the scan sequencer
package scan_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // True when no enabled channel sits above ch, i.e. ch closes the pass.
  function automatic logic is_last(input logic [N_CH-1:0] mask, input logic [SEL_W-1:0] ch);
    logic [N_CH-1:0] above;
    above = (mask >> ch) >> 1;
    return above == '0;
  endfunction

endpackage

// File: rtl/next_enabled_ch.sv
// rtl/next_enabled_ch.sv - rotating priority search for the next enabled channel after cur
module next_enabled_ch
  import scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrapped
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Candidates cur+1 .. cur+16 modulo 16; the last candidate is cur itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign wrapped = (nxt <= cur);

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - masked channel scanner with programmable dwell and single/continuous passes
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               pass_done
);

  state_t             state;
  logic [N_CH-1:0]    mask_q;
  logic               cont_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_inc;
  logic               expire;
  logic [SEL_W-1:0]   first_ch;
  logic [SEL_W-1:0]   next_ch;
  logic               next_wrap;
  logic               first_wrap_unused;

  assign cnt_inc = cnt + 1'b1;
  assign expire  = (cnt == dwell_q);

  next_enabled_ch u_first (
    .mask    (ch_mask),
    .cur     (LAST_IDX),
    .nxt     (first_ch),
    .wrapped (first_wrap_unused)
  );

  next_enabled_ch u_next (
    .mask    (mask_q),
    .cur     (sel),
    .nxt     (next_ch),
    .wrapped (next_wrap)
  );

  // pass_done is registered, so it is raised one cycle ahead: whenever the
  // upcoming cycle will be the expiry cycle of the pass's final channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      cnt       <= '0;
      mask_q    <= '0;
      cont_q    <= 1'b0;
      dwell_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop && ch_mask != '0) begin
            state     <= SCAN;
            mask_q    <= ch_mask;
            cont_q    <= continuous;
            dwell_q   <= dwell;
            sel       <= first_ch;
            cnt       <= '0;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            pass_done <= (dwell == '0) && is_last(ch_mask, first_ch);
          end
        end
        SCAN: begin
          if (stop || (expire && next_wrap && !cont_q)) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
            cnt       <= '0;
          end else if (!expire) begin
            cnt       <= cnt_inc;
            pass_done <= (cnt_inc == dwell_q) && is_last(mask_q, sel);
          end else begin
            sel       <= next_ch;
            cnt       <= '0;
            pass_done <= (dwell_q == '0) && is_last(mask_q, next_ch);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] ch_mask = '0;
  logic [7:0]  dwell = '0;
  logic [3:0]  sel;
  logic        sel_valid;
  logic        busy;
  logic        pass_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .pass_done  (pass_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sel"},       32'(sel),       32'd0);
    check({tag, " sel_valid"}, 32'(sel_valid), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " pass_done"}, 32'(pass_done), 32'd0);
  endtask

  int seq8421 [12] = '{0, 0, 0, 5, 5, 5, 10, 10, 10, 15, 15, 15};

  initial begin
    step();
    step();
    rst = 1'b0;
    check_idle("reset");

    // full mask, dwell 0, single pass
    ch_mask = 16'hFFFF; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ffff sel[%0d]", i), 32'(sel), 32'(i));
      check($sformatf("ffff busy[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("ffff valid[%0d]", i), 32'(sel_valid), 32'd1);
      check($sformatf("ffff done[%0d]", i), 32'(pass_done), 32'(i == 15));
      step();
    end
    check_idle("ffff end");

    // sparse mask, dwell 2
    ch_mask = 16'h8421; dwell = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("8421 sel[%0d]", i), 32'(sel), 32'(seq8421[i]));
      check($sformatf("8421 busy[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("8421 done[%0d]", i), 32'(pass_done), 32'(i == 11));
      step();
    end
    check_idle("8421 end");

    // single channel, continuous, dwell 1
    ch_mask = 16'h0010; dwell = 8'd1; continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("cont sel[%0d]", i), 32'(sel), 32'd4);
      check($sformatf("cont busy[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("cont done[%0d]", i), 32'(pass_done), 32'(i % 2 == 1));
      step();
    end
    // first dwell cycle of the channel: stop mid-dwell
    check("cont pre-stop sel", 32'(sel), 32'd4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("stop");

    // start and stop together in IDLE
    ch_mask = 16'hFFFF; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_idle("start+stop");
    step();
    check_idle("start+stop later");

    // start with empty mask
    ch_mask = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    check_idle("empty mask");

    // mask change mid-scan has no effect, then reset mid-scan
    ch_mask = 16'h00F0; dwell = 8'd3; continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("mid sel first", 32'(sel), 32'd4);
    ch_mask = 16'h0001; dwell = 8'd0; continuous = 1'b0;
    step(); step(); step();
    check("mid sel hold", 32'(sel), 32'd4);
    check("mid done", 32'(pass_done), 32'd0);
    step();
    check("mid sel next", 32'(sel), 32'd5);
    check("mid busy", 32'(busy), 32'd1);
    start = 1'b1; ch_mask = 16'hFFFF; rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check_idle("rst mid-scan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Sequential channel scanner that generates the 4-bit channel index consumed by `decoder_4to16`, stepping through a masked subset of 16 channels with a programmable dwell time per channel. It sits directly upstream of the decoder. The decoder's one-hot output is qualified by `sel_valid`, which yields time-multiplexed one-hot strobes for LED/keypad scanning or channel muxing. It supports single-pass and continuous modes, immediate stop, and a per-pass completion pulse.

## Interface
- `DWELL_W`, default 8: width of dwell count; each channel is held `dwell+1` cycles.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a scan; ignored while `busy`.
- `stop` in 1: abort the scan; has priority over `start`.
- `continuous` in 1: 1 = wrap and repeat forever, 0 = one pass; sampled with `start`.
- `ch_mask` in 16: enabled channels, bit i = channel i; sampled with `start`.
- `dwell` in DWELL_W: hold cycles minus one; sampled with `start`.
- `sel` out 4: current channel index, drives decoder input `a`.
- `sel_valid` out 1: `sel` is live; gates the decoder output.
- `busy` out 1: scan in progress.
- `pass_done` out 1: one-cycle pulse on the final cycle of the last enabled channel of each pass.

## Operation
- Reset: state IDLE; `sel`=0, `sel_valid`=0, `busy`=0, `pass_done`=0; dwell counter=0; latched mask/mode/dwell=0.
- States:
  - IDLE: outputs inactive, `sel`=0.
  - SCAN: `sel_valid`=1, `busy`=1.
- IDLE→SCAN requires all of:
  - `start`=1
  - `stop`=0
  - `ch_mask`≠0
- On that transition:
  - latch `ch_mask`, `continuous`, `dwell`
  - `sel` ← lowest set bit of `ch_mask`
  - counter ← 0
- `start` with `ch_mask`=0 is ignored: remains IDLE, no pulse.
- In SCAN the counter increments each cycle. When counter == latched dwell (expiry):
  - `sel` ← next set mask bit above `sel`, wrapping 15→0; the counter resets to 0.
  - A wrap (next index ≤ current, including a single enabled channel) marks end of pass.
  - `pass_done`=1 in the expiry cycle.
  - If not continuous, return to IDLE instead of advancing.
- Masked channels are never presented, not even for one cycle.
- `stop`=1 in SCAN: next cycle IDLE, all outputs at reset values, no `pass_done`.
- `start` in SCAN is ignored. `ch_mask`, `dwell` and `continuous` changes in SCAN have no effect.
- `rst` mid-scan: next cycle all reset values regardless of other inputs.

## Timing
- Start latency: `start` sampled at edge t → `sel`/`sel_valid`/`busy` valid after edge t (cycle t+1).
- Each enabled channel is held exactly `dwell+1` cycles; `dwell`=0 gives 1-cycle steps.
- Single pass over k enabled channels has `busy` high for k·(`dwell`+1) cycles.
  - `pass_done` is coincident with the last of those cycles.
  - IDLE follows on the next cycle.
- Continuous mode has no gap between passes: the first channel follows the last channel on the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Stop latency is 1 cycle.

## Structure
- Package `scan_pkg`:
  - `N_CH`=16, `SEL_W`=4
  - state enum {IDLE, SCAN}
- Sub-module `next_enabled_ch`: combinational rotating priority search.
  - Inputs: `mask[15:0]`, `cur[3:0]`.
  - Outputs: `nxt[3:0]`, `wrapped`.
  - Also used with `cur`=15 to find the first channel at start.
- Top level holds the FSM, dwell counter and latched configuration registers.

## Test plan
- Reset, then `ch_mask`=16'hFFFF, `dwell`=0, `continuous`=0, `start` pulse → `sel` = 0..15 on consecutive cycles; `pass_done` with `sel`=15; `busy` low the next cycle.
- `ch_mask`=16'h8421, `dwell`=2, one pass → `sel` sequence 0,0,0,5,5,5,10,10,10,15,15,15; `pass_done` on the 12th cycle.
- `ch_mask`=16'h0010, `continuous`=1, `dwell`=1 → `sel`=4 constant, `pass_done` every 2 cycles, `busy` stays high.
- Continuous scan with `stop` asserted mid-dwell → next cycle `sel_valid`=0, `busy`=0, `sel`=0, no `pass_done`. Then `start`+`stop` together in IDLE → stays IDLE.
- `start` with `ch_mask`=0 → no change. Then a `start` pulse, a change to `ch_mask`, and `rst` mid-scan → outputs at reset values after the edge; the mask change has no effect.
